seg_pwm_driver: RTL and testbench

SEG_PWM_DRIVER -- requirements
Module: seg_pwm_driver

---
 rtl/seg_pwm_driver.sv | 146 ++++++++++++++
 tb/tb_seg_pwm_driver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_pwm_driver.sv
// seg_pwm_driver: 7-segment + decimal-point driver with frame-synchronous
// pattern/brightness commit, 16-slot PWM dimming and frame-counted blinking.
module seg_pwm_driver #(
  parameter int unsigned PRESCALE     = 4,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       dp_in,
  input  logic       seg_valid,
  input  logic [3:0] brightness,
  input  logic       blink_en,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic       frame_start,
  output logic       pending
);

  localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [3:0] SLOT_LAST  = 4'hF;
  localparam logic [3:0] DUTY_FULL  = 4'hF;

  // Timebase
  logic [7:0] presc_q, presc_d;
  logic [3:0] slot_q, slot_d;
  logic       slot_tick;
  logic       frame_wrap;

  // Blink
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       blink_phase_q, blink_phase_d;

  // Pattern path
  logic [6:0] shadow_seg_q;
  logic       shadow_dp_q;
  logic       pending_q;
  logic [6:0] act_seg_q;
  logic       act_dp_q;
  logic [3:0] act_duty_q;
  logic       frame_start_q;

  // Output stage
  logic       gate_on;
  logic       blank;
  logic       drive_on;
  logic [6:0] seg_raw;
  logic       dp_raw;
  logic [6:0] seg_pin_d, seg_pin_q;
  logic       dp_pin_d, dp_pin_q;

  assign slot_tick  = (presc_q == PRESC_LAST);
  assign frame_wrap = slot_tick && (slot_q == SLOT_LAST);

  // Next-state for prescaler, slot counter and blink counter
  always_comb begin
    presc_d       = presc_q + 8'd1;
    slot_d        = slot_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (slot_tick) begin
      presc_d = '0;
      slot_d  = slot_q + 4'd1;
    end
    if (frame_wrap) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  // Timebase and blink state registers; frame_start marks the slot wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q       <= '0;
      slot_q        <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      slot_q        <= slot_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      frame_start_q <= frame_wrap;
    end
  end

  // Shadow capture and frame-synchronous commit; a strobe in the commit
  // cycle lands in the shadow after the commit, so pending stays set
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_seg_q <= '0;
      shadow_dp_q  <= 1'b0;
      pending_q    <= 1'b0;
      act_seg_q    <= '0;
      act_dp_q     <= 1'b0;
      act_duty_q   <= '0;
    end else begin
      if (frame_start_q) begin
        act_seg_q  <= shadow_seg_q;
        act_dp_q   <= shadow_dp_q;
        act_duty_q <= brightness;
        pending_q  <= 1'b0;
      end
      if (seg_valid) begin
        shadow_seg_q <= seg_in;
        shadow_dp_q  <= dp_in;
        pending_q    <= 1'b1;
      end
    end
  end

  // PWM gate, blink blanking and pin polarity
  always_comb begin
    gate_on   = (act_duty_q == DUTY_FULL) || (slot_q < act_duty_q);
    blank     = blink_en && blink_phase_q;
    drive_on  = gate_on && !blank;
    seg_raw   = act_seg_q & {7{drive_on}};
    dp_raw    = act_dp_q & drive_on;
    seg_pin_d = ACTIVE_LOW ? ~seg_raw : seg_raw;
    dp_pin_d  = ACTIVE_LOW ? ~dp_raw : dp_raw;
  end

  // Registered pin drivers; reset level is the inactive pin level
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_pin_q <= {7{ACTIVE_LOW}};
      dp_pin_q  <= ACTIVE_LOW;
    end else begin
      seg_pin_q <= seg_pin_d;
      dp_pin_q  <= dp_pin_d;
    end
  end

  assign seg_out     = seg_pin_q;
  assign dp_out      = dp_pin_q;
  assign frame_start = frame_start_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_seg_pwm_driver.sv
// Self-checking bench for seg_pwm_driver: two parameterisations share stimulus,
// a cycle-count based reference model is compared every cycle, and directed
// phases pin the model with hand-computed values.
module tb_seg_pwm_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [6:0] seg_in = '0;
  logic       dp_in = 1'b0;
  logic       seg_valid = 1'b0;
  logic [3:0] brightness = 4'd15;
  logic       blink_en = 1'b0;

  logic [6:0] seg_out0, seg_out1;
  logic       dp_out0, dp_out1, fs0, fs1, pend0, pend1;

  seg_pwm_driver #(.PRESCALE(4), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .reset(reset), .seg_in(seg_in), .dp_in(dp_in),
    .seg_valid(seg_valid), .brightness(brightness), .blink_en(blink_en),
    .seg_out(seg_out0), .dp_out(dp_out0), .frame_start(fs0), .pending(pend0));

  seg_pwm_driver #(.PRESCALE(2), .BLINK_FRAMES(3), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .reset(reset), .seg_in(seg_in), .dp_in(dp_in),
    .seg_valid(seg_valid), .brightness(brightness), .blink_en(blink_en),
    .seg_out(seg_out1), .dp_out(dp_out1), .frame_start(fs1), .pending(pend1));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int prm_p(int i);  return (i == 0) ? 4 : 2; endfunction
  function automatic int prm_bf(int i); return (i == 0) ? 2 : 3; endfunction
  function automatic bit prm_al(int i); return (i == 0) ? 1'b0 : 1'b1; endfunction

  int         m_t[2];
  logic [6:0] m_sh[2], m_act[2];
  logic       m_shdp[2], m_actdp[2], m_pend[2];
  logic [3:0] m_duty[2];
  logic [6:0] e_seg[2];
  logic       e_dp[2], e_fs[2], e_pend[2];
  bit         m_ok = 1'b0;

  task automatic model_step(input int i);
    int p, fl, slot, frame;
    bit on, al;
    logic [6:0] raw;
    p  = prm_p(i);
    fl = 16 * p;
    al = prm_al(i);
    if (reset) begin
      m_t[i] = 0;
      m_sh[i] = '0; m_act[i] = '0; m_shdp[i] = 0; m_actdp[i] = 0;
      m_pend[i] = 0; m_duty[i] = '0;
      e_seg[i] = al ? 7'h7F : 7'h00;
      e_dp[i] = al; e_fs[i] = 0; e_pend[i] = 0;
    end else begin
      slot  = (m_t[i] / p) % 16;
      frame = m_t[i] / fl;
      on = (m_duty[i] == 4'd15 || slot < int'(m_duty[i])) &&
           !(blink_en && ((frame / prm_bf(i)) % 2 == 1));
      raw = on ? m_act[i] : 7'h00;
      e_seg[i] = al ? ~raw : raw;
      e_dp[i]  = (on && m_actdp[i]) ^ al;
      if (m_t[i] > 0 && m_t[i] % fl == 0) begin
        m_act[i] = m_sh[i]; m_actdp[i] = m_shdp[i];
        m_duty[i] = brightness; m_pend[i] = 0;
      end
      if (seg_valid) begin
        m_sh[i] = seg_in; m_shdp[i] = dp_in; m_pend[i] = 1;
      end
      m_t[i]++;
      e_fs[i]   = (m_t[i] % fl == 0);
      e_pend[i] = m_pend[i];
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    if (reset) m_ok = 1'b1;
  end

  // every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      chk("seg_out0", 32'(seg_out0), 32'(e_seg[0]));
      chk("dp_out0", 32'(dp_out0), 32'(e_dp[0]));
      chk("frame_start0", 32'(fs0), 32'(e_fs[0]));
      chk("pending0", 32'(pend0), 32'(e_pend[0]));
      chk("seg_out1", 32'(seg_out1), 32'(e_seg[1]));
      chk("dp_out1", 32'(dp_out1), 32'(e_dp[1]));
      chk("frame_start1", 32'(fs1), 32'(e_fs[1]));
      chk("pending1", 32'(pend1), 32'(e_pend[1]));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_fs0(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs0 && n < 300);
    chk("fs0_timeout", 32'(fs0), 32'd1);
  endtask

  task automatic strobe(input logic [6:0] s, input logic d);
    @(negedge clk);
    seg_in = s; dp_in = d; seg_valid = 1'b1;
    @(negedge clk);
    seg_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt_on, cnt_off, bad;
    bit saw5b, saw4f;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_seg0", 32'(seg_out0), 32'h00);
    chk("rst_seg1", 32'(seg_out1), 32'h7F);
    chk("rst_dp1", 32'(dp_out1), 32'h1);
    chk("rst_pend0", 32'(pend0), 32'h0);

    // first frame_start 64 clk after release (one negedge already consumed)
    wait_fs0(n);
    chk("first_fs_latency", 32'(n + 1), 32'd64);

    // steady full-brightness pattern
    repeat (10) @(negedge clk);
    strobe(7'h3F, 1'b1);
    chk("pend_after_strobe", 32'(pend0), 32'd1);
    wait_fs0(n);
    chk("pend_at_fs", 32'(pend0), 32'd1);
    repeat (2) @(negedge clk);
    chk("seg_3F", 32'(seg_out0), 32'h3F);
    chk("pend_cleared", 32'(pend0), 32'd0);
    cnt_on = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (seg_out0 == 7'h3F && dp_out0) cnt_on++;
    end
    chk("seg_3F_steady", 32'(cnt_on), 32'd100);

    // duty 4 of 16
    brightness = 4'd4;
    strobe(7'h06, 1'b0);
    wait_fs0(n);
    wait_fs0(n);
    cnt_on = 0; cnt_off = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (seg_out0 == 7'h06) cnt_on++;
      if (seg_out0 == 7'h00) cnt_off++;
    end
    chk("duty4_on", 32'(cnt_on), 32'd16);
    chk("duty4_off", 32'(cnt_off), 32'd48);

    // last write wins within a frame
    brightness = 4'd15;
    wait_fs0(n);
    strobe(7'h5B, 1'b0);
    repeat (2) @(negedge clk);
    strobe(7'h4F, 1'b0);
    saw5b = 0; saw4f = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (seg_out0 == 7'h5B) saw5b = 1;
      if (seg_out0 == 7'h4F) saw4f = 1;
    end
    chk("never_5B", 32'(saw5b), 32'd0);
    chk("saw_4F", 32'(saw4f), 32'd1);

    // strobe coinciding with frame_start
    wait_fs0(n);
    seg_in = 7'h79; dp_in = 1'b0; seg_valid = 1'b1;
    @(negedge clk);
    seg_valid = 1'b0;
    chk("pend_fs_strobe", 32'(pend0), 32'd1);
    bad = 0; n = 0;
    while (!fs0 && n < 100) begin
      if (seg_out0 != 7'h4F) bad++;
      @(negedge clk);
      n++;
    end
    chk("held_old_pattern", 32'(bad), 32'd0);
    chk("fs_reached", 32'(fs0), 32'd1);
    repeat (2) @(negedge clk);
    chk("new_after_next_fs", 32'(seg_out0), 32'h79);

    // blinking: 2 frames on, 2 frames off
    blink_en = 1'b1;
    @(negedge clk);
    cnt_on = 0; cnt_off = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (seg_out0 == 7'h79) cnt_on++;
      if (seg_out0 == 7'h00) cnt_off++;
    end
    chk("blink_on", 32'(cnt_on), 32'd128);
    chk("blink_off", 32'(cnt_off), 32'd128);
    blink_en = 1'b0;
    @(negedge clk);
    cnt_on = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (seg_out0 == 7'h79) cnt_on++;
    end
    chk("blink_disabled", 32'(cnt_on), 32'd256);

    // reset with pending set on the active-low instance
    strobe(7'h55, 1'b1);
    chk("pend1_before_rst", 32'(pend1), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_pend_seg1", 32'(seg_out1), 32'h7F);
    chk("rst_pend_dp1", 32'(dp_out1), 32'd1);
    chk("rst_pend_pend1", 32'(pend1), 32'd0);
    cnt_on = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (seg_out1 == 7'h7F && dp_out1) cnt_on++;
    end
    chk("no_commit_after_rst", 32'(cnt_on), 32'd100);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      seg_valid = ($urandom_range(0, 19) == 0);
      seg_in    = 7'($urandom);
      dp_in     = 1'($urandom);
      if ($urandom_range(0, 149) == 0) brightness = 4'($urandom);
      if ($urandom_range(0, 399) == 0) blink_en = ~blink_en;
      reset = ($urandom_range(0, 1499) == 0);
    end
    @(negedge clk);
    reset = 1'b0; seg_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
